seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector for the board-level sequence exercises. One input bit is consumed per rising edge of a debounced `next` button. The block tracks progress toward a configurable bit pattern, with overlap/non-overlap modes and a saturating match counter. A run of consecutive 1s of configurable length traps it in a lock state that only `clear` or reset leaves. `state_display` drives the board LEDs.

## Interface
- `PAT_LEN`, 3: pattern length in bits; must be 1..15.
- `PATTERN`, 3'b010: pattern bits; `PATTERN[PAT_LEN-1]` is the first bit received.
- `OVERLAP`, 1: 1 means matches may overlap; 0 means history restarts empty after each match.
- `LOCK_RUN`, 3: number of consecutive 1s that cause lock; 0 disables lock.
- `CNT_W`, 8: width of `match_count`.
- `SW`, derived as `$clog2(PAT_LEN+2)`: width of `state_display`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `next` in 1: step button, already debounced and synchronous to `clk`.
- `in` in 1: data bit, sampled on a step.
- `clear` in 1: synchronous clear, active-high.
- `out` out 1: level, high while progress == `PAT_LEN` and not locked.
- `match_pulse` out 1: high for one `clk` cycle per counted match.
- `match_count` out `CNT_W`: counted matches, saturating.
- `locked` out 1: lock state.
- `state_display` out `SW`: progress value (0..`PAT_LEN`), or all-ones while locked.

## Operation
- **Step detect:** `step = next & ~next_q`, where `next_q` is a registered copy of `next`. A held `next` produces exactly one step.
- **Progress register `prog`** holds 0..`PAT_LEN` = the number of pattern bits currently matched.
- **Update on step with bit b (not locked):**
  - The history is the first `prog` pattern bits followed by b.
  - New `prog` = the largest j ≤ `PAT_LEN` such that the first j pattern bits equal the last j bits of that history.
  - Exception: if `prog` == `PAT_LEN` and `OVERLAP` = 0, the history is b alone, so new `prog` is 1 if b equals the first pattern bit, else 0.
- **Match:** a step that moves `prog` to `PAT_LEN` is a match.
  - `match_pulse` = 1 for that cycle.
  - `match_count` increments, saturating at 2^`CNT_W` − 1.
- **Run counter:** counts consecutive stepped 1s, resets on a stepped 0, and saturates at `LOCK_RUN`.
  - When a step brings the run to `LOCK_RUN` (`LOCK_RUN` > 0), `locked` is set.
  - Lock has priority: on that step there is no match pulse and no count increment, `prog` is forced to 0, and `out` = 0.
- **While locked:** steps are ignored; `prog`, count and run are frozen; `out` = 0; `state_display` = all-ones.
- **`clear`:** sets `prog`, run and `match_count` to 0, clears `locked` and `match_pulse`, and captures `next` into `next_q`. It has priority over a simultaneous step; that step is discarded.
- **Transition function:** purely combinational from `prog`, `PATTERN` and b, implemented with elaborated loops. There is no per-pattern hand-coded case.

## Timing
- **Reset values (immediately on `reset`=0, without a clock):**
  - `prog`=0, run=0, `locked`=0, `match_count`=0, `match_pulse`=0.
  - `next_q`=1, so a button held through reset release does not step.
- All outputs are registered or decoded from registers. No combinational path from `in` or `next` reaches any output.
- **Latency:** the `next` rising edge is seen at clk edge N; `prog`, `out`, `match_pulse`, `match_count`, `locked` and `state_display` update at edge N+1.
- `match_pulse` lasts exactly one cycle, even if `next` is held.
- A reset asserted mid-operation takes effect asynchronously. Release is synchronous to the next `clk` edge. No step fires on the first cycle after release unless `next` rises.
- Default parameters reproduce the legacy 3-bit display encoding:
  - Progress 0..3 for pattern 010.
  - Lock after 111, displayed as 7.

## Test plan
- **Defaults, basic match:** steps 0,1,0 → `state_display` 1,2,3; `out`=1 after the third step; `match_count`=1; one `match_pulse`.
- **Overlap mode:** with `OVERLAP`=1, steps 0,1,0,1,0 → `match_count`=2, `prog` ends at 3. With `OVERLAP`=0, the same stimulus → `match_count`=1, `prog` ends at 1.
- **Lock:** steps 1,1,1 → `locked`=1, `state_display`=7, `out`=0. Steps 0,1,0 that follow → no change. `clear` pulse → `state_display`=0, `locked`=0.
- **Button hold:** `next` held high for 20 cycles with `in`=0 → exactly one step (`prog`=1). `next` held through reset release → no step.
- **Saturation:** with `CNT_W`=2 and `LOCK_RUN`=0, five matches of 010 → `match_count` stays at 3 after the fourth match; `match_pulse` still fires on the fifth.
- **Async reset mid-sequence:** after steps 0,1, drive `reset`=0 between clock edges → all outputs reach their reset values before the next edge. A step coincident with `clear` → discarded, `prog`=0.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial pattern detector stepped by a debounced button, with overlap control,
// a saturating match counter and a lock state entered after a run of 1s.
module seq_detect_param #(
    parameter int unsigned        PAT_LEN  = 3,
    parameter logic [PAT_LEN-1:0] PATTERN  = 3'b010,
    parameter bit                 OVERLAP  = 1'b1,
    parameter int unsigned        LOCK_RUN = 3,
    parameter int unsigned        CNT_W    = 8,
    localparam int unsigned       SW       = $clog2(PAT_LEN + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next,
    input  logic             in,
    input  logic             clear,
    output logic             out,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             locked,
    output logic [SW-1:0]    state_display
);

    localparam int unsigned RW      = (LOCK_RUN > 0) ? $clog2(LOCK_RUN + 1) : 1;
    localparam bit          LOCK_EN = (LOCK_RUN > 0);

    typedef enum logic [0:0] {StTrack, StLocked} state_e;

    state_e        state_q;
    logic          next_q;
    logic          step_q;
    logic          bit_q;
    logic [SW-1:0] prog_q;
    logic [RW-1:0] run_q;
    logic [SW-1:0] prog_nxt;
    logic [RW-1:0] run_inc;
    logic          lock_hit;

    // Longest pattern prefix that is a suffix of (first p pattern bits, b).
    function automatic logic [SW-1:0] next_prog(input int unsigned p, input logic b);
        int unsigned pat;
        int unsigned hist;
        int unsigned best;
        pat  = 32'(PATTERN);
        hist = ((pat >> (PAT_LEN - p)) << 1) | 32'(b);
        best = 0;
        for (int unsigned j = 1; j <= PAT_LEN; j++) begin
            if ((j <= p + 1) && ((hist & ((32'd1 << j) - 32'd1)) == (pat >> (PAT_LEN - j)))) begin
                best = j;
            end
        end
        return SW'(best);
    endfunction

    always_comb begin
        prog_nxt = '0;
        for (int unsigned p = 0; p <= PAT_LEN; p++) begin
            if (prog_q == SW'(p)) begin
                // Without overlap a completed match restarts from empty history.
                prog_nxt = next_prog((!OVERLAP && (p == PAT_LEN)) ? 32'd0 : p, bit_q);
            end
        end
    end

    always_comb begin
        run_inc  = (run_q == RW'(LOCK_RUN)) ? run_q : run_q + 1'b1;
        lock_hit = LOCK_EN && bit_q && (run_inc == RW'(LOCK_RUN));
    end

    // Step is registered along with its data bit, so state moves one edge after
    // the rising edge of next is first sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_q      <= 1'b1;
            step_q      <= 1'b0;
            bit_q       <= 1'b0;
            prog_q      <= '0;
            run_q       <= '0;
            state_q     <= StTrack;
            match_count <= '0;
            match_pulse <= 1'b0;
        end else if (clear) begin
            next_q      <= next;
            step_q      <= 1'b0;
            bit_q       <= in;
            prog_q      <= '0;
            run_q       <= '0;
            state_q     <= StTrack;
            match_count <= '0;
            match_pulse <= 1'b0;
        end else begin
            next_q      <= next;
            step_q      <= next & ~next_q;
            bit_q       <= in;
            match_pulse <= 1'b0;
            if (step_q && (state_q == StTrack)) begin
                if (lock_hit) begin
                    state_q <= StLocked;
                    prog_q  <= '0;
                    run_q   <= run_inc;
                end else begin
                    prog_q <= prog_nxt;
                    run_q  <= bit_q ? run_inc : '0;
                    if (prog_nxt == SW'(PAT_LEN)) begin
                        match_pulse <= 1'b1;
                        if (match_count != '1) begin
                            match_count <= match_count + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign locked        = (state_q == StLocked);
    assign out           = !locked && (prog_q == SW'(PAT_LEN));
    assign state_display = locked ? '1 : prog_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: defaults, non-overlap variant and a
// narrow-counter variant with lock disabled, all fed the same button stimulus.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic reset;
    logic nxt;
    logic din;
    logic clear;

    logic       d_out, d_pulse, d_locked;
    logic [7:0] d_cnt;
    logic [2:0] d_sd;
    logic       n_out, n_pulse, n_locked;
    logic [7:0] n_cnt;
    logic [2:0] n_sd;
    logic       s_out, s_pulse, s_locked;
    logic [1:0] s_cnt;
    logic [2:0] s_sd;

    int checks = 0;
    int errors = 0;
    int d_pulses = 0;
    int s_pulses = 0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .reset(reset), .next(nxt), .in(din), .clear(clear),
        .out(d_out), .match_pulse(d_pulse), .match_count(d_cnt),
        .locked(d_locked), .state_display(d_sd)
    );

    seq_detect_param #(.OVERLAP(1'b0)) dut_nov (
        .clk(clk), .reset(reset), .next(nxt), .in(din), .clear(clear),
        .out(n_out), .match_pulse(n_pulse), .match_count(n_cnt),
        .locked(n_locked), .state_display(n_sd)
    );

    seq_detect_param #(.CNT_W(2), .LOCK_RUN(0)) dut_sat (
        .clk(clk), .reset(reset), .next(nxt), .in(din), .clear(clear),
        .out(s_out), .match_pulse(s_pulse), .match_count(s_cnt),
        .locked(s_locked), .state_display(s_sd)
    );

    always @(negedge clk) begin
        if (d_pulse === 1'b1) d_pulses++;
        if (s_pulse === 1'b1) s_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        din = b;
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        nxt   = 1'b0;
        din   = 1'b0;
        clear = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_sd", d_sd, 0);
        check("rst_out", d_out, 0);
        check("rst_cnt", d_cnt, 0);
        check("rst_locked", d_locked, 0);
        check("rst_pulse", d_pulse, 0);
        @(negedge clk) reset = 1'b1;

        // First step with latency probe
        @(negedge clk);
        din = 1'b0;
        nxt = 1'b1;
        @(negedge clk);
        check("latency_before", d_sd, 0);
        nxt = 1'b0;
        @(negedge clk);
        check("step0_sd", d_sd, 1);
        step(1'b1);
        check("step1_sd", d_sd, 2);
        step(1'b0);
        check("match_sd", d_sd, 3);
        check("match_out", d_out, 1);
        check("match_cnt", d_cnt, 1);
        check("match_pulse", d_pulse, 1);
        check("nov_cnt1", n_cnt, 1);
        check("sat_cnt1", s_cnt, 1);
        @(negedge clk);
        check("pulse_one_cycle", d_pulse, 0);
        check("out_level", d_out, 1);
        check("pulse_count", d_pulses, 1);

        // Continue 1,0: overlap vs non-overlap
        step(1'b1);
        step(1'b0);
        check("ovl_sd", d_sd, 3);
        check("ovl_cnt", d_cnt, 2);
        check("nov_sd", n_sd, 1);
        check("nov_cnt", n_cnt, 1);
        check("sat_cnt2", s_cnt, 2);

        // Three more matches on the 2-bit counter
        step(1'b1);
        step(1'b0);
        check("sat_cnt3", s_cnt, 3);
        step(1'b1);
        step(1'b0);
        check("sat_cnt4", s_cnt, 3);
        check("sat_pulse4", s_pulse, 1);
        step(1'b1);
        step(1'b0);
        check("sat_cnt5", s_cnt, 3);
        check("sat_pulse5", s_pulse, 1);
        check("def_cnt5", d_cnt, 5);
        check("nov_cnt3", n_cnt, 3);
        check("nov_sd3", n_sd, 3);
        @(negedge clk);
        check("sat_pulses", s_pulses, 5);

        pulse_clear();
        check("clr_sd", d_sd, 0);
        check("clr_cnt", d_cnt, 0);
        check("clr_out", d_out, 0);

        // Lock on 1,1,1
        step(1'b1);
        step(1'b1);
        check("prelock_locked", d_locked, 0);
        check("prelock_sd", d_sd, 0);
        step(1'b1);
        check("lock_locked", d_locked, 1);
        check("lock_sd", d_sd, 7);
        check("lock_out", d_out, 0);
        check("lock_pulse", d_pulse, 0);
        check("nov_locked", n_locked, 1);
        check("sat_unlocked", s_locked, 0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        check("locked_sd", d_sd, 7);
        check("locked_cnt", d_cnt, 0);
        check("locked_still", d_locked, 1);
        check("nolock_cnt", s_cnt, 1);
        pulse_clear();
        check("unlock_sd", d_sd, 0);
        check("unlock_locked", d_locked, 0);

        // Held button gives one step
        @(negedge clk);
        din = 1'b0;
        nxt = 1'b1;
        repeat (20) @(negedge clk);
        nxt = 1'b0;
        @(negedge clk);
        check("hold_sd", d_sd, 1);

        // Button held through reset release
        @(negedge clk);
        reset = 1'b0;
        nxt   = 1'b1;
        @(negedge clk) reset = 1'b1;
        repeat (4) @(negedge clk);
        check("hold_reset_sd", d_sd, 0);
        nxt = 1'b0;
        @(negedge clk);

        // Asynchronous reset between edges
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        check("pre_areset_sd", d_sd, 2);
        check("pre_areset_cnt", d_cnt, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_sd", d_sd, 0);
        check("areset_cnt", d_cnt, 0);
        check("areset_out", d_out, 0);
        check("areset_locked", d_locked, 0);
        check("areset_pulse", d_pulse, 0);
        @(negedge clk) reset = 1'b1;

        // Step coincident with clear is dropped
        step(1'b0);
        check("pre_clr_sd", d_sd, 1);
        @(negedge clk);
        din   = 1'b1;
        nxt   = 1'b1;
        clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        repeat (2) @(negedge clk);
        nxt = 1'b0;
        @(negedge clk);
        check("clr_step_sd", d_sd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
